ultrasonic_echo_model: RTL

Responder side of the trig/echo ultrasonic ranging interface, emulating an HC-SR04-style sensor. The block watches the trig line driven by the car's ranging initiator. When it sees a valid trig pulse, it waits the sensor's burst delay, then drives echo high for a width proportional to a programmed distance. It is used for hardware-in-the-loop bring-up on the spare GPIO header and as the bench model for ranging and wall-sense verification.

---
 rtl/ultrasonic_echo_model_pkg.sv | 42 ++++
 rtl/ultrasonic_echo_model_if.sv | 20 ++
 rtl/ultrasonic_echo_model_sync_edge.sv | 37 +++
 rtl/ultrasonic_echo_model.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/ultrasonic_echo_model_pkg.sv
// Shared constants, state encoding and helpers for the trig/echo ranging
// blocks (echo responder model and ranging initiator).
package ultrasonic_pkg;

  localparam int unsigned CYCLES_PER_US  = 50;
  localparam int unsigned MIN_TRIG_US    = 10;
  localparam int unsigned BURST_DELAY_US = 250;
  localparam int unsigned US_PER_CM      = 58;
  localparam int unsigned MIN_CM         = 2;
  localparam int unsigned MAX_CM         = 400;
  localparam int unsigned NO_ECHO_US     = 38000;
  localparam int unsigned HOLDOFF_US     = 100;

  // Echo/delay counter width: 38000 us at 50 MHz is 1,900,000 cycles.
  localparam int unsigned CNT_W = 22;
  localparam int unsigned CM_W  = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG_HIGH = 3'd1,
    ST_DELAY     = 3'd2,
    ST_ECHO      = 3'd3,
    ST_HOLDOFF   = 3'd4
  } state_e;

  function automatic int unsigned us_to_cyc(input int unsigned us,
                                            input int unsigned cyc_per_us);
    return us * cyc_per_us;
  endfunction

  localparam int unsigned MIN_TRIG_CYC = us_to_cyc(MIN_TRIG_US, CYCLES_PER_US);
  localparam int unsigned BURST_CYC    = us_to_cyc(BURST_DELAY_US, CYCLES_PER_US);
  localparam int unsigned NO_ECHO_CYC  = us_to_cyc(NO_ECHO_US, CYCLES_PER_US);
  localparam int unsigned HOLDOFF_CYC  = us_to_cyc(HOLDOFF_US, CYCLES_PER_US);

  function automatic logic [CM_W-1:0] clamp_cm(input logic [CM_W-1:0] cm);
    if (cm < CM_W'(MIN_CM)) return CM_W'(MIN_CM);
    if (cm > CM_W'(MAX_CM)) return CM_W'(MAX_CM);
    return cm;
  endfunction

endpackage

// File: rtl/ultrasonic_echo_model_if.sv
// Trig/echo ranging bus. master = initiator side, slave = sensor side.
interface ultrasonic_echo_model_if;
  logic                           trig;
  logic [ultrasonic_pkg::CM_W-1:0] distance_cm;
  logic                           object_present;
  logic                           echo;
  logic                           busy;
  logic                           trig_err;
  logic [ultrasonic_pkg::CM_W-1:0] last_cm;

  modport master (
    output trig, distance_cm, object_present,
    input  echo, busy, trig_err, last_cm
  );

  modport slave (
    input  trig, distance_cm, object_present,
    output echo, busy, trig_err, last_cm
  );
endinterface

// File: rtl/ultrasonic_echo_model_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a delayed copy
// for single-cycle rise/fall detection.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic meta_q, sync_q, dly_q;
  logic meta_d, sync_d, dly_d;

  // Next values of the synchronizer chain and edge-detect copy
  always_comb begin
    meta_d = d_async;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  // Chain registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~dly_q;
  assign fall = ~sync_q & dly_q;
endmodule

// File: rtl/ultrasonic_echo_model.sv
// HC-SR04-style echo responder: validates a trig pulse, waits the burst
// delay, then drives echo for a width proportional to the programmed
// distance (or the no-echo timeout when no object is present).
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | waiting for a fresh trig rise
// ST_TRIG_HIGH | measuring trig high time
// ST_DELAY     | burst delay before echo rises
// ST_ECHO      | echo high for the latched width
// ST_HOLDOFF   | dead time, trig ignored
module ultrasonic_echo_model
  import ultrasonic_pkg::*;
#(
  // Clock rate override for boards not running at 50 MHz.
  parameter int unsigned CYC_PER_US = CYCLES_PER_US
) (
  input  logic                  clk,
  input  logic                  reset,
  ultrasonic_echo_model_if.slave bus
);
  localparam int unsigned MIN_TRIG_C = us_to_cyc(MIN_TRIG_US, CYC_PER_US);
  localparam int unsigned BURST_C    = us_to_cyc(BURST_DELAY_US, CYC_PER_US);
  localparam int unsigned NO_ECHO_C  = us_to_cyc(NO_ECHO_US, CYC_PER_US);
  localparam int unsigned HOLD_C     = us_to_cyc(HOLDOFF_US, CYC_PER_US);
  localparam int unsigned WID_W      = $clog2(MIN_TRIG_C + 1);

  localparam logic [WID_W-1:0] WID_MAX   = WID_W'(MIN_TRIG_C);
  localparam logic [CNT_W-1:0] BURST_LD  = CNT_W'(BURST_C - 1);
  // Zero holdoff still spends one cycle in ST_HOLDOFF.
  localparam logic [CNT_W-1:0] HOLD_LD   = (HOLD_C == 0) ? '0 : CNT_W'(HOLD_C - 1);
  localparam logic [CNT_W-1:0] NO_ECHO_W = CNT_W'(NO_ECHO_C);
  localparam logic [CNT_W-1:0] CM_MULT   = CNT_W'(US_PER_CM * CYC_PER_US);

  logic trig_s, trig_rise, trig_fall;

  state_e           state_q, state_d;
  logic [WID_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_q, w_d;
  logic [CM_W-1:0]  dist_q, dist_d;
  logic             pres_q, pres_d;
  logic [CM_W-1:0]  last_q, last_d;
  logic             echo_q, echo_d;
  logic             err_q, err_d;
  logic             width_ok;

  sync_edge u_trig_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (bus.trig),
    .sync    (trig_s),
    .rise    (trig_rise),
    .fall    (trig_fall)
  );

  assign width_ok = (width_q >= WID_MAX);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      width_q <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
      dist_q  <= '0;
      pres_q  <= 1'b0;
      last_q  <= '0;
      echo_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      dist_q  <= dist_d;
      pres_q  <= pres_d;
      last_q  <= last_d;
      echo_q  <= echo_d;
      err_q   <= err_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (trig_rise) state_d = ST_TRIG_HIGH;
      ST_TRIG_HIGH: if (trig_fall) state_d = width_ok ? ST_DELAY : ST_IDLE;
      ST_DELAY:     if (cnt_q == '0) state_d = ST_ECHO;
      ST_ECHO:      if (cnt_q == '0) state_d = ST_HOLDOFF;
      ST_HOLDOFF:   if (cnt_q == '0) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Counters, measurement latch and registered outputs
  always_comb begin
    width_d = width_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    dist_d  = dist_q;
    pres_d  = pres_q;
    last_d  = last_q;
    err_d   = 1'b0;
    echo_d  = (state_q == ST_ECHO);
    case (state_q)
      ST_IDLE: width_d = '0;
      ST_TRIG_HIGH: begin
        if (trig_s && (width_q != WID_MAX)) width_d = width_q + WID_W'(1);
        if (trig_fall) begin
          if (width_ok) begin
            dist_d = clamp_cm(bus.distance_cm);
            pres_d = bus.object_present;
            // Product is formed once here so the echo countdown only loads it.
            w_d    = bus.object_present
                     ? {{(CNT_W-CM_W){1'b0}}, clamp_cm(bus.distance_cm)} * CM_MULT
                     : NO_ECHO_W;
            cnt_d  = BURST_LD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DELAY: cnt_d = (cnt_q == '0) ? (w_q - CNT_W'(1)) : (cnt_q - CNT_W'(1));
      ST_ECHO: begin
        if (cnt_q == '0) begin
          cnt_d  = HOLD_LD;
          last_d = pres_q ? dist_q : '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLDOFF: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = '0;
    endcase
  end

  assign bus.echo     = echo_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.trig_err = err_q;
  assign bus.last_cm  = last_q;
endmodule
